// File: rtl/dtw_result_axis_tx_if.sv
// ---------------------------------------------------------------------------
// dtw_result_axis_tx_if
// AXI4-Stream bundle carrying DTW result beats from dtw_result_axis_tx toward
// the DMA engine.
//   TVALID  master->slave  head word valid
//   TDATA   master->slave  head word (DATA_WIDTH bits)
//   TSTRB   master->slave  byte strobes, always all ones
//   TLAST   master->slave  final beat of the current packet
//   TREADY  slave->master  downstream ready
// ---------------------------------------------------------------------------
interface dtw_result_axis_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      TVALID;
    logic [DATA_WIDTH-1:0]     TDATA;
    logic [DATA_WIDTH/8-1:0]   TSTRB;
    logic                      TLAST;
    logic                      TREADY;

    modport master (
        output TVALID,
        output TDATA,
        output TSTRB,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TSTRB,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/dtw_result_axis_tx.sv
// ---------------------------------------------------------------------------
// dtw_result_axis_tx
// Buffers DTW result words written by dtw_core into its sink-FIFO port and
// emits them as AXI4-Stream beats, grouped into packets of pkt_len words with
// TLAST on the final beat of each packet.
// Ports:
//   M_AXIS_ACLK     sole clock
//   M_AXIS_ARESETN  asynchronous active-low reset
//   dtw_fifo_wren   core write strobe (dropped while full)
//   dtw_fifo_din    core result word
//   dtw_fifo_full   buffer full, core must hold off
//   pkt_len         words per packet, 0 behaves as 1
//   fifo_level      entries currently held
//   overflow        sticky flag: a write was attempted while full
//   m_axis          AXI4-Stream master (TVALID/TDATA/TSTRB/TLAST/TREADY)
// ---------------------------------------------------------------------------
module dtw_result_axis_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int PKT_LEN_WIDTH        = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              dtw_fifo_wren,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   dtw_fifo_din,
    output logic                              dtw_fifo_full,
    input  logic [PKT_LEN_WIDTH-1:0]          pkt_len,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow,
    dtw_result_axis_tx_if.master              m_axis
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]            LP_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]            LP_CNT_1  = CW'(1);
    localparam logic [AW-1:0]            LP_PTR_1  = AW'(1);
    localparam logic [PKT_LEN_WIDTH-1:0] LP_PKT_0  = {PKT_LEN_WIDTH{1'b0}};
    localparam logic [PKT_LEN_WIDTH-1:0] LP_PKT_1  = PKT_LEN_WIDTH'(1);

    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]                   r_wr_ptr;
    logic [AW-1:0]                   r_rd_ptr;
    logic [CW-1:0]                   r_count;
    logic [PKT_LEN_WIDTH-1:0]        r_beat_cnt;
    logic [PKT_LEN_WIDTH-1:0]        r_pkt_len_q;
    logic                            r_overflow;

    logic                            w_full;
    logic                            w_valid;
    logic                            w_last;
    logic                            w_wr;
    logic                            w_rd;
    logic [PKT_LEN_WIDTH-1:0]        w_pkt_len_eff;

    // Full and valid are derived from the registered occupancy only, so a
    // same-cycle pop never lets a write slip into a full buffer.
    assign w_full        = (r_count == LP_DEPTH);
    assign w_valid       = (r_count != {CW{1'b0}});
    assign w_wr          = dtw_fifo_wren && !w_full;
    assign w_rd          = w_valid && m_axis.TREADY;
    assign w_pkt_len_eff = (pkt_len == LP_PKT_0) ? LP_PKT_1 : pkt_len;
    assign w_last        = w_valid && (r_beat_cnt == (r_pkt_len_q - LP_PKT_1));

    assign m_axis.TVALID = w_valid;
    assign m_axis.TDATA  = r_mem[r_rd_ptr];
    assign m_axis.TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
    assign m_axis.TLAST  = w_last;
    assign dtw_fifo_full = w_full;
    assign fifo_level    = r_count;
    assign overflow      = r_overflow;

    // Storage array; the write slot is never the head while data is held.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= dtw_fifo_din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + LP_CNT_1;
                2'b01:   r_count <= r_count - LP_CNT_1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packetiser: packet length is sampled only while idle between packets,
    // so changes during a packet or a stall take effect on the next one.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_beat_cnt  <= LP_PKT_0;
            r_pkt_len_q <= LP_PKT_1;
        end else begin
            if ((r_beat_cnt == LP_PKT_0) && !w_valid) begin
                r_pkt_len_q <= w_pkt_len_eff;
            end
            if (w_rd) begin
                r_beat_cnt <= w_last ? LP_PKT_0 : (r_beat_cnt + LP_PKT_1);
            end
        end
    end

    // Sticky overflow: any write attempt while full, regardless of a same-cycle pop.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_overflow <= 1'b0;
        end else if (dtw_fifo_wren && w_full) begin
            r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dtw_result_axis_tx.sv
// ---------------------------------------------------------------------------
// tb_dtw_result_axis_tx
// Self-checking bench for dtw_result_axis_tx. A queue-based reference model
// tracks buffered words, the packet beat position and the sticky overflow.
// ---------------------------------------------------------------------------
module tb_dtw_result_axis_tx;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int PLW   = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wren = 1'b0;
    logic [W-1:0]   din = '0;
    logic [PLW-1:0] pkt_len = '0;
    logic           full;
    logic [4:0]     level;
    logic           ovf;

    dtw_result_axis_tx_if #(.DATA_WIDTH(W)) axis_if ();

    dtw_result_axis_tx #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH),
        .PKT_LEN_WIDTH(PLW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .dtw_fifo_wren  (wren),
        .dtw_fifo_din   (din),
        .dtw_fifo_full  (full),
        .pkt_len        (pkt_len),
        .fifo_level     (level),
        .overflow       (ovf),
        .m_axis         (axis_if.master)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    int           m_beat;
    int           m_len;
    bit           m_ovf;
    // Observed handshakes (data, last) as seen on the bus
    logic [W-1:0] hs_data[$];
    bit           hs_last[$];

    wire [8:0] dut_status = {axis_if.TVALID, axis_if.TLAST, full, level, ovf};

    function automatic logic [8:0] exp_status();
        bit v;
        bit l;
        v = (m_q.size() != 0);
        l = v && (m_beat == m_len - 1);
        return {v, l, (m_q.size() == DEPTH), 5'(m_q.size()), m_ovf};
    endfunction

    task automatic model_reset();
        m_q.delete();
        hs_data.delete();
        hs_last.delete();
        m_beat = 0;
        m_len  = 1;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wren = 1'b0;
        axis_if.TREADY = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs presented at the edge.
    task automatic tick();
        bit v, l, f, wr, rd;
        v  = (m_q.size() != 0);
        l  = v && (m_beat == m_len - 1);
        f  = (m_q.size() == DEPTH);
        wr = wren && !f;
        rd = v && axis_if.TREADY;
        if (axis_if.TVALID && axis_if.TREADY) begin
            hs_data.push_back(axis_if.TDATA);
            hs_last.push_back(axis_if.TLAST);
        end
        if (m_beat == 0 && !v) m_len = (pkt_len == 0) ? 1 : int'(pkt_len);
        if (wren && f) m_ovf = 1'b1;
        if (rd) begin
            void'(m_q.pop_front());
            m_beat = l ? 0 : m_beat + 1;
        end
        if (wr) m_q.push_back(din);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (dut_status !== 9'b0) $display("FAIL reset_status got %b exp %b", dut_status, 9'b0);
        else n_pass++;
        n_total++;
        if (axis_if.TSTRB !== 4'hF) $display("FAIL reset_tstrb got %h exp %h", axis_if.TSTRB, 4'hF);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [W-1:0] w[3];
        bit           exp_last[3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        pkt_len = 16'd3;
        axis_if.TREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                w[i] = $urandom;
                din  = w[i];
                wren = 1'b1;
            end else begin
                wren = 1'b0;
            end
            tick();
            n_total++;
            if (dut_status !== exp_status()) $display("FAIL basic_status c%0d got %b exp %b", i, dut_status, exp_status());
            else n_pass++;
            if (i >= 0 && i < 3) begin
                n_total++;
                if (axis_if.TDATA !== w[i]) $display("FAIL basic_data c%0d got %h exp %h", i, axis_if.TDATA, w[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (hs_data.size() != 3) $display("FAIL basic_beats got %0d exp 3", hs_data.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < hs_data.size(); i++) begin
            n_total++;
            if (hs_last[i] !== exp_last[i]) $display("FAIL basic_last b%0d got %0d exp %0d", i, hs_last[i], exp_last[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_overflow();
        logic [W-1:0] w[DEPTH];
        do_reset();
        pkt_len = 16'd4;
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom;
            din  = w[i];
            wren = 1'b1;
            tick();
            n_total++;
            if (dut_status !== exp_status()) $display("FAIL fill_status c%0d got %b exp %b", i, dut_status, exp_status());
            else n_pass++;
        end
        n_total++;
        if ({full, level, ovf} !== {1'b1, 5'd16, 1'b0}) $display("FAIL full_flags got %b exp %b", {full, level, ovf}, {1'b1, 5'd16, 1'b0});
        else n_pass++;
        din = $urandom;
        tick();
        wren = 1'b0;
        n_total++;
        if ({level, ovf} !== {5'd16, 1'b1}) $display("FAIL overflow_flags got %b exp %b", {level, ovf}, {5'd16, 1'b1});
        else n_pass++;
        axis_if.TREADY = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        n_total++;
        if (hs_data.size() != DEPTH) $display("FAIL drain_count got %0d exp %0d", hs_data.size(), DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH && i < hs_data.size(); i++) begin
            n_total++;
            if ({hs_data[i], hs_last[i]} !== {w[i], ((i % 4) == 3)})
                $display("FAIL drain_beat b%0d got %h/%0d exp %h/%0d", i, hs_data[i], hs_last[i], w[i], ((i % 4) == 3));
            else n_pass++;
        end
    endtask

    task automatic test_pktlen0();
        do_reset();
        pkt_len = 16'd0;
        axis_if.TREADY = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wren = (i < 4);
            din  = $urandom;
            tick();
        end
        n_total++;
        if (hs_last.size() != 4) $display("FAIL len0_count got %0d exp 4", hs_last.size());
        else n_pass++;
        for (int i = 0; i < hs_last.size(); i++) begin
            n_total++;
            if (hs_last[i] !== 1'b1) $display("FAIL len0_last b%0d got %0d exp 1", i, hs_last[i]);
            else n_pass++;
        end
    endtask

    task automatic test_len_change();
        bit exp_last[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        pkt_len = 16'd4;
        for (int i = 0; i < 4; i++) begin
            wren = 1'b1;
            din  = $urandom;
            tick();
        end
        wren = 1'b0;
        axis_if.TREADY = 1'b1;
        tick();
        pkt_len = 16'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (dut_status !== exp_status()) $display("FAIL lenchg_status c%0d got %b exp %b", i, dut_status, exp_status());
            else n_pass++;
        end
        for (int i = 0; i < 7; i++) begin
            wren = (i < 4);
            din  = $urandom;
            tick();
        end
        n_total++;
        if (hs_last.size() != 8) $display("FAIL lenchg_count got %0d exp 8", hs_last.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < hs_last.size(); i++) begin
            n_total++;
            if (hs_last[i] !== exp_last[i]) $display("FAIL lenchg_last b%0d got %0d exp %0d", i, hs_last[i], exp_last[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_pop_drop();
        logic [W-1:0] w[DEPTH];
        do_reset();
        pkt_len = 16'd1;
        for (int i = 0; i < DEPTH; i++) begin
            w[i] = $urandom;
            din  = w[i];
            wren = 1'b1;
            tick();
        end
        din = $urandom;
        axis_if.TREADY = 1'b1;
        tick();
        wren = 1'b0;
        axis_if.TREADY = 1'b0;
        n_total++;
        if ({full, level, ovf} !== {1'b0, 5'd15, 1'b1}) $display("FAIL popdrop_flags got %b exp %b", {full, level, ovf}, {1'b0, 5'd15, 1'b1});
        else n_pass++;
        n_total++;
        if (axis_if.TDATA !== w[1]) $display("FAIL popdrop_head got %h exp %h", axis_if.TDATA, w[1]);
        else n_pass++;
        axis_if.TREADY = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        n_total++;
        if (hs_data.size() != DEPTH) $display("FAIL popdrop_count got %0d exp %0d", hs_data.size(), DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH && i < hs_data.size(); i++) begin
            n_total++;
            if (hs_data[i] !== w[i]) $display("FAIL popdrop_data b%0d got %h exp %h", i, hs_data[i], w[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall_reset();
        logic [W-1:0] cap_data;
        logic         cap_last;
        bit           exp_last[3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        pkt_len = 16'd3;
        for (int i = 0; i < 5; i++) begin
            wren = 1'b1;
            din  = $urandom;
            tick();
        end
        wren = 1'b0;
        axis_if.TREADY = 1'b1;
        tick();
        axis_if.TREADY = 1'b0;
        cap_data = m_q[0];
        cap_last = (m_beat == m_len - 1);
        for (int i = 0; i < 6; i++) begin
            pkt_len = 16'($urandom_range(0, 7));
            tick();
            n_total++;
            if ({axis_if.TDATA, axis_if.TLAST} !== {cap_data, cap_last})
                $display("FAIL stall_hold c%0d got %h/%0d exp %h/%0d", i, axis_if.TDATA, axis_if.TLAST, cap_data, cap_last);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (dut_status !== 9'b0) $display("FAIL async_reset got %b exp %b", dut_status, 9'b0);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        pkt_len = 16'd2;
        axis_if.TREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wren = (i < 3);
            din  = $urandom;
            tick();
        end
        n_total++;
        if (hs_last.size() != 3) $display("FAIL postrst_count got %0d exp 3", hs_last.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < hs_last.size(); i++) begin
            n_total++;
            if (hs_last[i] !== exp_last[i]) $display("FAIL postrst_last b%0d got %0d exp %0d", i, hs_last[i], exp_last[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        pkt_len = 16'd3;
        for (int i = 0; i < 400; i++) begin
            wren = ($urandom_range(0, 99) < 60);
            din  = $urandom;
            axis_if.TREADY = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 9) == 0) pkt_len = 16'($urandom_range(0, 5));
            tick();
            n_total++;
            if (dut_status !== exp_status()) $display("FAIL rand_status c%0d got %b exp %b", i, dut_status, exp_status());
            else n_pass++;
            if (m_q.size() != 0) begin
                n_total++;
                if (axis_if.TDATA !== m_q[0]) $display("FAIL rand_data c%0d got %h exp %h", i, axis_if.TDATA, m_q[0]);
                else n_pass++;
            end
        end
        wren = 1'b0;
    endtask

    initial begin
        axis_if.TREADY = 1'b0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_pktlen0();
        test_len_change();
        test_full_pop_drop();
        test_stall_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
